// File: rtl/serial_adder_n_if.sv
// Operand/result bundle for serial_adder_n.
// Optional macro SERIAL_ADDER_SUB_EN adds the 'sub' request bit.
interface serial_adder_n_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, s, c, v);
    modport slave  (input start, a, b, cin, sub, output busy, done, s, c, v);
`else
    modport master (output start, a, b, cin, input busy, done, s, c, v);
    modport slave  (input start, a, b, cin, output busy, done, s, c, v);
`endif
endinterface

// File: rtl/serial_adder_n.sv
// Digit-serial adder: WIDTH-bit operands added DIGIT bits per clock through a registered carry.
// Macro SERIAL_ADDER_SUB_EN (optional) enables subtraction via the interface 'sub' bit.
module serial_adder_n #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_adder_n_if.slave   bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_q, c_d;
    logic             v_q, v_d;

    logic [DIGIT-1:0] dig_s;
    logic [DIGIT:0]   dc;
    logic [WIDTH-1:0] acc_shift;
    logic [WIDTH-1:0] b_in;
    logic             carry_in;
    logic             accept;

    // Ripple chain across one digit; dc[DIGIT-1] is the carry into the top bit of the digit.
    assign dc[0] = carry_q;
    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
            assign dig_s[gi]  = acc_q[gi] ^ b_q[gi] ^ dc[gi];
            assign dc[gi + 1] = (acc_q[gi] & b_q[gi]) | (dc[gi] & (acc_q[gi] ^ b_q[gi]));
        end
    endgenerate

    // The A shift register doubles as the sum register: consumed digits leave at the LSB,
    // sum digits enter at the MSB, so after N steps it holds the full result.
    generate
        if (DIGIT == WIDTH) begin : g_full
            assign acc_shift = dig_s;
        end else begin : g_part
            assign acc_shift = {dig_s, acc_q[WIDTH-1:DIGIT]};
        end
    endgenerate

`ifdef SERIAL_ADDER_SUB_EN
    assign b_in     = bus.sub ? ~bus.b : bus.b;
    assign carry_in = bus.sub ? 1'b1 : bus.cin;
`else
    assign b_in     = bus.b;
    assign carry_in = bus.cin;
`endif

    assign accept = bus.start && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        c_d     = c_q;
        v_d     = v_q;

        case (state_q)
            IDLE: state_d = IDLE;
            RUN: begin
                acc_d   = acc_shift;
                b_d     = b_q >> DIGIT;
                carry_d = dc[DIGIT];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    s_d     = acc_shift;
                    c_d     = dc[DIGIT];
                    v_d     = dc[DIGIT] ^ dc[DIGIT-1];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d = RUN;
            acc_d   = bus.a;
            b_d     = b_in;
            carry_d = carry_in;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            c_q     <= c_d;
            v_q     <= v_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.s    = s_q;
    assign bus.c    = c_q;
    assign bus.v    = v_q;
endmodule

// File: doc/serial_adder_n.md
# serial_adder_n

Parametrised multi-cycle adder: captures two WIDTH-bit operands plus carry-in on a start pulse, then adds them DIGIT bits per clock through a registered carry. Reports sum, carry-out and signed overflow with a one-cycle done pulse. This is the clocked, width-generic successor to the single-bit full adder. It sits in the arithmetic datapath where area matters more than latency.

## Interface
- WIDTH, 8, operand/sum width in bits (≥2)
- DIGIT, 1, bits added per RUN cycle; must divide WIDTH exactly (1 ≤ DIGIT ≤ WIDTH)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  operand A, sampled with start
- b  input  WIDTH  operand B, sampled with start
- cin  input  1  carry-in, sampled with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; s/c/v valid
- s  output  WIDTH  sum, registered
- c  output  1  carry-out of MSB
- v  output  1  signed overflow, i.e. carry into MSB XOR carry out of MSB

## Operation
- N = WIDTH/DIGIT; an internal digit counter runs 0..N-1.
- States: IDLE, RUN, DONE.
- IDLE, start=1: latch a, b and cin into shift registers, counter=0, go to RUN. IDLE, start=0: stay.
- RUN: each edge adds the low DIGIT bits of A and B plus the carry register. The result digit shifts into the sum register from the MSB side. The carry register is updated. counter++.
  - At counter=N-1: go to DONE and transfer the sum, final carry and overflow to s, c and v.
  - start is ignored in RUN.
- DONE: done=1 for exactly this cycle.
  - start=1: latch new operands and go directly to RUN (back-to-back).
  - start=0: go to IDLE.
- s, c and v hold their last result until the next DONE transfer. They never show partial sums.
- Arithmetic is modulo 2^WIDTH. c is bit WIDTH of a+b+cin. v is computed from the carry into bit WIDTH-1 (the MSB) and the carry out of it.
- Reset: rst_n low forces the state to IDLE immediately, regardless of clock. busy=0, done=0, s=0, c=0, v=0, and internal registers are cleared.
- Reset during RUN aborts the operation. No done is produced, and outputs read 0 after reset.

## Timing
- Start accepted at edge T0 → busy=1 after T0 → done=1 after edge T0+N, for one cycle.
- With WIDTH=8, DIGIT=1: 8 RUN cycles; DIGIT=8 gives 1 RUN cycle.
- Throughput with back-to-back start: one result per N+1 cycles.
- done and busy are never high together.
- busy falls on the same edge that done rises.

## Configuration
- Macro SERIAL_ADDER_SUB_EN.
- Defined: adds input port sub (1 bit), sampled with start. When sub=1, B is inverted as it is latched and the initial carry is forced to 1 (cin ignored), giving s = a − b. In that case c=1 means no borrow, and v is signed-subtract overflow. When sub=0, behaviour is identical to the add-only build.
- Not defined: no sub port; add only.

## Test plan
- WIDTH=8, DIGIT=1, a=8'h5A, b=8'h33, cin=0, start pulse → busy for 8 cycles, then done with s=8'h8D, c=0, v=1.
- WIDTH=8, DIGIT=1, a=8'hFF, b=8'h01, cin=1 → s=8'h01, c=1, v=0. Between start and done, s/c/v still show the previous result.
- WIDTH=8, DIGIT=4, a=8'h0F, b=8'h01, cin=0 → done 2 edges after start is accepted, s=8'h10, c=0, v=0.
- start held high continuously with operands changing every cycle:
  - Only the operands present at IDLE/DONE acceptance are used.
  - start during RUN is ignored.
  - Second operation begins from DONE with no IDLE cycle.
- rst_n pulsed low at the 4th RUN cycle → outputs 0 asynchronously, no done. A subsequent start with a=8'h01, b=8'h01 gives s=8'h02.
- SERIAL_ADDER_SUB_EN defined, sub=1, a=8'h10, b=8'h20 → s=8'hF0, c=0, v=0. Then sub=1, a=8'h80, b=8'h01 → s=8'h7F, c=1, v=1.
